// File: rtl/fc_layer_engine_if.sv
// Stream, weight-ROM and result handshake bundle for fc_layer_engine.
// class_idx exists only when FC_ARGMAX_EN is defined.
interface fc_layer_engine_if #(
    parameter int DATAWIDTH    = 16,
    parameter int INPUT_NODES  = 784,
    parameter int OUTPUT_NODES = 2,
    parameter int MAC_UNITS    = 16
);
    localparam int BEATS = INPUT_NODES / MAC_UNITS;
    localparam int AW    = $clog2(BEATS * OUTPUT_NODES);

    logic                              start;
    logic [DATAWIDTH*MAC_UNITS-1:0]    in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              weight_en;
    logic [AW-1:0]                     weight_addr;
    logic [DATAWIDTH*MAC_UNITS-1:0]    weights;
    logic [DATAWIDTH*OUTPUT_NODES-1:0] bias;
    logic [DATAWIDTH*OUTPUT_NODES-1:0] out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              busy;
    logic                              done;
`ifdef FC_ARGMAX_EN
    localparam int CW = $clog2(OUTPUT_NODES);
    logic [CW-1:0]                     class_idx;
`endif

    modport master (
        output start, in_data, in_valid, weights, bias, out_ready,
        input  in_ready, weight_en, weight_addr, out_data, out_valid, busy, done
`ifdef FC_ARGMAX_EN
        , input class_idx
`endif
    );

    modport slave (
        input  start, in_data, in_valid, weights, bias, out_ready,
        output in_ready, weight_en, weight_addr, out_data, out_valid, busy, done
`ifdef FC_ARGMAX_EN
        , output class_idx
`endif
    );
endinterface

// File: rtl/fc_layer_engine.sv
// Streaming fully-connected layer: y[n] = sat(sum_i x[i]*w[n][i] + b[n]) in signed fixed point.
// Build macro FC_ARGMAX_EN adds a registered class_idx output (index of the largest result).
module fc_layer_engine #(
    parameter int DATAWIDTH    = 16,
    parameter int FRAC_BITS    = 8,
    parameter int INPUT_NODES  = 784,
    parameter int OUTPUT_NODES = 2,
    parameter int MAC_UNITS    = 16,
    parameter int ACC_W        = 2*DATAWIDTH + $clog2(INPUT_NODES)
) (
    input  logic             clk,
    input  logic             reset,
    fc_layer_engine_if.slave fc
);
    localparam int DW    = DATAWIDTH;
    localparam int BEATS = INPUT_NODES / MAC_UNITS;
    localparam int AW    = $clog2(BEATS * OUTPUT_NODES);
    localparam int BW    = $clog2(BEATS + 1);
    localparam int NW    = $clog2(OUTPUT_NODES);
    localparam int SW    = ACC_W + 1;
    localparam logic [BW-1:0]        BEAT_LAST = BW'(BEATS - 1);
    localparam logic [NW-1:0]        NODE_LAST = NW'(OUTPUT_NODES - 1);
    localparam logic signed [SW-1:0] SAT_MAX   = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN   = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    generate
        if (INPUT_NODES % MAC_UNITS != 0) begin : g_bad_beats
            $error("INPUT_NODES must be a multiple of MAC_UNITS");
        end
        if (OUTPUT_NODES < 2) begin : g_bad_nodes
            $error("OUTPUT_NODES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_BIAS  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                       state_r;
    state_t                       state_s;
    logic                         weight_en_s;
    logic [BW-1:0]                beat_r;
    logic [NW-1:0]                node_r;
    logic [AW-1:0]                addr_r;
    logic [DW*MAC_UNITS-1:0]      x_r;
    logic signed [ACC_W-1:0]      acc_r [OUTPUT_NODES];
    logic signed [ACC_W-1:0]      mac_sum_s;
    logic [DW-1:0]                res_s [OUTPUT_NODES];
    logic [DW*OUTPUT_NODES-1:0]   out_data_r;
    logic                         out_valid_r;
    logic                         done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state; ROM reads are issued one cycle ahead of the MAC cycle that consumes them.
    always_comb begin
        state_s     = state_r;
        weight_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fc.start) state_s = ST_FETCH;
                else          state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (fc.in_valid) begin
                    state_s     = ST_MAC;
                    weight_en_s = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_MAC: begin
                if (node_r == NODE_LAST) begin
                    if (beat_r == BEAT_LAST) state_s = ST_BIAS;
                    else                     state_s = ST_FETCH;
                end else begin
                    state_s     = ST_MAC;
                    weight_en_s = 1'b1;
                end
            end
            ST_BIAS: state_s = ST_OUT;
            ST_OUT: begin
                if (fc.out_ready) state_s = ST_IDLE;
                else              state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Dot product of the latched beat with the current ROM word, each product sign-extended.
    always_comb begin
        logic [DW-1:0]          xk;
        logic [DW-1:0]          wk;
        logic signed [2*DW-1:0] pk;
        mac_sum_s = '0;
        xk        = '0;
        wk        = '0;
        pk        = '0;
        for (int k = 0; k < MAC_UNITS; k++) begin
            xk        = x_r[k*DW +: DW];
            wk        = fc.weights[k*DW +: DW];
            pk        = $signed({{DW{xk[DW-1]}}, xk}) * $signed({{DW{wk[DW-1]}}, wk});
            mac_sum_s = mac_sum_s + {{(ACC_W-2*DW){pk[2*DW-1]}}, pk};
        end
    end

    // Bias add at accumulator scale, floor back to FRAC_BITS, then saturate to DW.
    always_comb begin
        logic signed [SW-1:0] sum_v;
        logic signed [SW-1:0] shr_v;
        logic [DW-1:0]        bias_v;
        sum_v  = '0;
        shr_v  = '0;
        bias_v = '0;
        for (int n = 0; n < OUTPUT_NODES; n++) begin
            res_s[n] = '0;
        end
        for (int n = 0; n < OUTPUT_NODES; n++) begin
            bias_v = fc.bias[n*DW +: DW];
            sum_v  = {acc_r[n][ACC_W-1], acc_r[n]}
                   + ({{(SW-DW){bias_v[DW-1]}}, bias_v} <<< FRAC_BITS);
            shr_v  = sum_v >>> FRAC_BITS;
            if (shr_v > SAT_MAX) begin
                res_s[n] = SAT_MAX[DW-1:0];
            end else if (shr_v < SAT_MIN) begin
                res_s[n] = SAT_MIN[DW-1:0];
            end else begin
                res_s[n] = shr_v[DW-1:0];
            end
        end
    end

`ifdef FC_ARGMAX_EN
    logic [NW-1:0] best_idx_s;
    logic [NW-1:0] class_idx_r;

    // Strict greater-than scan so ties keep the lowest index.
    always_comb begin
        logic signed [DW-1:0] best_v;
        best_idx_s = '0;
        best_v     = res_s[0];
        for (int n = 1; n < OUTPUT_NODES; n++) begin
            if ($signed(res_s[n]) > best_v) begin
                best_v     = res_s[n];
                best_idx_s = NW'(n);
            end else begin
                best_idx_s = best_idx_s;
            end
        end
    end

    assign fc.class_idx = class_idx_r;
`endif

    // Datapath: accumulators, counters, ROM address, results and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_r      <= '0;
            node_r      <= '0;
            addr_r      <= '0;
            x_r         <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            for (int n = 0; n < OUTPUT_NODES; n++) begin
                acc_r[n] <= '0;
            end
`ifdef FC_ARGMAX_EN
            class_idx_r <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fc.start) begin
                        beat_r <= '0;
                        node_r <= '0;
                        addr_r <= '0;
                        for (int n = 0; n < OUTPUT_NODES; n++) begin
                            acc_r[n] <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fc.in_valid) begin
                        x_r    <= fc.in_data;
                        node_r <= '0;
                        addr_r <= addr_r + AW'(1);
                    end
                end
                ST_MAC: begin
                    acc_r[node_r] <= acc_r[node_r] + mac_sum_s;
                    if (node_r == NODE_LAST) begin
                        node_r <= '0;
                        beat_r <= beat_r + BW'(1);
                    end else begin
                        node_r <= node_r + NW'(1);
                        addr_r <= addr_r + AW'(1);
                    end
                end
                ST_BIAS: begin
                    for (int n = 0; n < OUTPUT_NODES; n++) begin
                        out_data_r[n*DW +: DW] <= res_s[n];
                    end
                    out_valid_r <= 1'b1;
`ifdef FC_ARGMAX_EN
                    class_idx_r <= best_idx_s;
`endif
                end
                ST_OUT: begin
                    if (fc.out_ready) begin
                        out_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign fc.in_ready    = (state_r == ST_FETCH);
    assign fc.busy        = (state_r != ST_IDLE);
    assign fc.weight_en   = weight_en_s;
    assign fc.weight_addr = addr_r;
    assign fc.out_data    = out_data_r;
    assign fc.out_valid   = out_valid_r;
    assign fc.done        = done_r;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine (DW=16, FRAC=8, IN=4, MAC=2, ON=2) with an arithmetic reference model.
module tb_fc_layer_engine;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int IN    = 4;
    localparam int MAC   = 2;
    localparam int ON    = 2;
    localparam int BEATS = IN / MAC;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   lat   = 0;

    logic [DW-1:0]       xs   [IN];
    logic [DW*MAC-1:0]   xw   [BEATS];
    logic [DW*MAC-1:0]   rom  [BEATS*ON];
    logic [DW-1:0]       exp_y [ON];
    logic [DW*ON-1:0]    exp_data = '0;
    int                  exp_cls  = 0;
    int                  addr_log [$];
    logic                hs_q = 1'b0;
    logic [DW*ON-1:0]    held;

    fc_layer_engine_if #(.DATAWIDTH(DW), .INPUT_NODES(IN), .OUTPUT_NODES(ON), .MAC_UNITS(MAC)) fc ();

    fc_layer_engine #(
        .DATAWIDTH(DW), .FRAC_BITS(FRAC), .INPUT_NODES(IN), .OUTPUT_NODES(ON), .MAC_UNITS(MAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fc    (fc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency weight ROM, logging every address it is asked for.
    always @(posedge clk) begin
        if (fc.weight_en) begin
            fc.weights <= rom[fc.weight_addr];
            addr_log.push_back(int'(fc.weight_addr));
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot product, floor scaling, clamp, argmax with lowest-index ties.
    function automatic void compute_model();
        longint s;
        longint r;
        logic [DW*MAC-1:0] word;
        logic signed [DW-1:0] wv;
        logic signed [DW-1:0] xv;
        logic signed [DW-1:0] bv;
        for (int i = 0; i < IN; i++) begin
            xw[i / MAC][(i % MAC)*DW +: DW] = xs[i];
        end
        for (int n = 0; n < ON; n++) begin
            s = 0;
            for (int i = 0; i < IN; i++) begin
                word = rom[(i / MAC)*ON + n];
                wv   = word[(i % MAC)*DW +: DW];
                xv   = xs[i];
                s    = s + longint'(xv) * longint'(wv);
            end
            bv = fc.bias[n*DW +: DW];
            r  = (s + longint'(bv) * (64'sd1 << FRAC)) >>> FRAC;
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            exp_y[n] = r[DW-1:0];
            exp_data[n*DW +: DW] = r[DW-1:0];
        end
        exp_cls = 0;
        for (int n = 1; n < ON; n++) begin
            if ($signed(exp_y[n]) > $signed(exp_y[exp_cls])) exp_cls = n;
        end
    endfunction

    task automatic set_all(input logic [DW-1:0] xv, input logic [DW-1:0] wv,
                           input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        for (int i = 0; i < IN; i++) xs[i] = xv;
        for (int a = 0; a < BEATS*ON; a++) begin
            for (int k = 0; k < MAC; k++) rom[a][k*DW +: DW] = wv;
        end
        fc.bias = {b1, b0};
        compute_model();
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(posedge clk) hs_q <= !reset && fc.out_valid && fc.out_ready;
    always @(negedge clk) begin
        if (!reset) begin
            chk("done_pulse", fc.done, hs_q);
            if (fc.in_ready)  chk("in_ready_busy", fc.busy, 1);
            if (fc.weight_en) chk("weight_en_busy", fc.busy, 1);
            if (fc.out_valid) begin
                chk("out_data", fc.out_data, exp_data);
`ifdef FC_ARGMAX_EN
                chk("class_idx", fc.class_idx, exp_cls);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        fc.start = 1'b1;
        tick();
        fc.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic feed_beats(input int nb, input int max_gap);
        int  gap;
        int  guard;
        logic got;
        for (int b = 0; b < nb; b++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                fc.in_valid = 1'b0;
                repeat (gap) tick();
            end
            fc.in_valid = 1'b1;
            fc.in_data  = xw[b];
            got   = 1'b0;
            guard = 0;
            while (!got && guard < 40) begin
                @(negedge clk);
                got = fc.in_ready;
                tick();
                guard++;
            end
            if (!got) chk("beat_accept_timeout", 0, 1);
        end
    endtask

    task automatic wait_out();
        int guard = 0;
        while (!fc.out_valid && guard < 60) begin
            tick();
            guard++;
        end
        chk("out_valid_seen", fc.out_valid, 1);
        lat = cyc - t0 + 1;
    endtask

    task automatic wait_done();
        int guard = 0;
        logic seen = 1'b0;
        while (!seen && guard < 20) begin
            tick();
            seen = fc.done;
            guard++;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic run_pass(input int max_gap);
        addr_log.delete();
        pulse_start();
        feed_beats(BEATS, max_gap);
        wait_out();
        wait_done();
    endtask

    initial begin
        fc.start     = 1'b0;
        fc.in_valid  = 1'b0;
        fc.in_data   = '0;
        fc.bias      = '0;
        fc.out_ready = 1'b1;
        set_all(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_out_data", fc.out_data, 0);
        chk("rst_out_valid", fc.out_valid, 0);
        chk("rst_busy", fc.busy, 0);
        chk("rst_in_ready", fc.in_ready, 0);
        chk("rst_weight_en", fc.weight_en, 0);
        chk("rst_weight_addr", fc.weight_addr, 0);

        // 1: 1.0 * 0.5 over four features, in_valid held high from before start.
        set_all(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        fc.in_data  = xw[0];
        fc.in_valid = 1'b1;
        tick();
        chk("t1_idle_ignores_valid", fc.in_ready, 0);
        run_pass(0);
        chk("t1_latency", lat, 8);
        chk("t1_result", fc.out_data, 32'h0200_0200);
        chk("t1_addr_count", addr_log.size(), 4);

        // 2: saturation at both ends.
        set_all(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
        run_pass(1);
        chk("t2_sat_pos", fc.out_data, 32'h7FFF_7FFF);
        set_all(16'h7FFF, 16'h8001, 16'h0000, 16'h0000);
        run_pass(1);
        chk("t2_sat_neg", fc.out_data, 32'h8000_8000);

        // 3: mixed-sign vector with random valid gaps; expected -1.9375 and 1.5625.
        fc.in_valid = 1'b0;
        xs[0] = 16'h0180; xs[1] = 16'hFF40; xs[2] = 16'h0300; xs[3] = 16'hFE00;
        rom[0] = {16'h0200, 16'h0100};
        rom[1] = {16'h0080, 16'hFF00};
        rom[2] = {16'h0040, 16'hFF80};
        rom[3] = {16'hFFC0, 16'h0100};
        fc.bias = {16'hFFF0, 16'h0010};
        compute_model();
        run_pass(3);
        chk("t3_result", fc.out_data, 32'h0190_FE10);
        chk("t3_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) chk("t3_addr_seq", addr_log[i], i);
        end

        // 4: consumer back-pressure; a start pulse while holding must be ignored.
        fc.out_ready = 1'b0;
        set_all(16'h0200, 16'h0100, 16'h0100, 16'hFF00);
        pulse_start();
        feed_beats(BEATS, 0);
        wait_out();
        held = fc.out_data;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) fc.start = 1'b1;
            tick();
            fc.start = 1'b0;
            chk("t4_valid_held", fc.out_valid, 1);
            chk("t4_data_held", fc.out_data, held);
            chk("t4_no_done", fc.done, 0);
        end
        chk("t4_result", fc.out_data, 32'h0700_0900);
        fc.out_ready = 1'b1;
        wait_done();
        tick();
        chk("t4_idle_after", fc.busy, 0);
        chk("t4_done_once", fc.done, 0);

        // 5: reset during MAC of beat 1, then a clean pass.
        set_all(16'h0200, 16'h0100, 16'h0000, 16'h0000);
        pulse_start();
        feed_beats(BEATS, 0);
        reset = 1'b1;
        tick();
        chk("t5_out_data", fc.out_data, 0);
        chk("t5_out_valid", fc.out_valid, 0);
        chk("t5_busy", fc.busy, 0);
        chk("t5_in_ready", fc.in_ready, 0);
        chk("t5_weight_en", fc.weight_en, 0);
        chk("t5_weight_addr", fc.weight_addr, 0);
        chk("t5_done", fc.done, 0);
        reset = 1'b0;
        fc.in_valid = 1'b0;
        tick();
        set_all(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_pass(0);
        chk("t5_fresh_result", fc.out_data, 32'h0200_0200);

`ifdef FC_ARGMAX_EN
        // 6: argmax from biases alone.
        set_all(16'h0000, 16'h0100, 16'hFF00, 16'h0080);
        run_pass(0);
        chk("t6_class_1", fc.class_idx, 1);
        set_all(16'h0000, 16'h0100, 16'h0080, 16'h0080);
        run_pass(0);
        chk("t6_class_tie", fc.class_idx, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
